idiv_radix4_iter: RTL and testbench

- Iterative unsigned integer divider, radix-4 restoring: 2 quotient bits per clock using precomputed 1x/2x/3x divisor multiples.
- Inverse companion of the 4-bit-digit multiplier stages in mathlib; serves the reciprocal/normalisation paths of the float units.
- Start/valid handshake. One division in flight; back-to-back issue allowed.

---
 rtl/idiv_radix4_iter_if.sv | 23 ++
 rtl/idiv_radix4_iter.sv | 111 +++++++++++
 tb/tb_idiv_radix4_iter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/idiv_radix4_iter_if.sv
// rtl/idiv_radix4_iter_if.sv - start/valid handshake bundle for the radix-4 divider
interface idiv_radix4_iter_if #(
    parameter int ibits = 22
);
    logic             i_ena;
    logic [ibits-1:0] i_a;
    logic [ibits-1:0] i_b;
    logic             o_busy;
    logic             o_valid;
    logic [ibits-1:0] o_quot;
    logic [ibits-1:0] o_rem;
    logic             o_dbz;

    modport master (
        output i_ena, i_a, i_b,
        input  o_busy, o_valid, o_quot, o_rem, o_dbz
    );

    modport slave (
        input  i_ena, i_a, i_b,
        output o_busy, o_valid, o_quot, o_rem, o_dbz
    );
endinterface

// File: rtl/idiv_radix4_iter.sv
// rtl/idiv_radix4_iter.sv - iterative unsigned radix-4 restoring divider, 2 quotient bits per clock
module idiv_radix4_iter #(
    parameter int ibits = 22
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    idiv_radix4_iter_if.slave    div_if
);
    localparam int W  = ibits + 2;
    localparam int N  = ibits / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [ibits-1:0] da_q;
    logic [ibits-1:0] pr_q;
    logic [ibits-1:0] q_q;
    logic [W-1:0]     m1_q, m2_q, m3_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, valid_q, dbz_q;
    logic [ibits-1:0] quot_q, rem_q;

    logic [W-1:0]     t_d;
    logic [W-1:0]     pr_d;
    logic [1:0]       digit_d;
    logic [ibits-1:0] q_d;

    // Remainder after each step is below m1, so only its low ibits bits are ever stored.
    always_comb begin
        t_d     = {pr_q, da_q[ibits-1:ibits-2]};
        digit_d = 2'd0;
        pr_d    = t_d;
        if (t_d >= m3_q) begin
            digit_d = 2'd3;
            pr_d    = t_d - m3_q;
        end else if (t_d >= m2_q) begin
            digit_d = 2'd2;
            pr_d    = t_d - m2_q;
        end else if (t_d >= m1_q) begin
            digit_d = 2'd1;
            pr_d    = t_d - m1_q;
        end
        q_d = {q_q[ibits-3:0], digit_d};
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            da_q    <= '0;
            pr_q    <= '0;
            q_q     <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            m3_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                    if (div_if.i_ena) begin
                        if (div_if.i_b != '0) begin
                            da_q    <= div_if.i_a;
                            pr_q    <= '0;
                            q_q     <= '0;
                            m1_q    <= {2'b00, div_if.i_b};
                            m2_q    <= {1'b0, div_if.i_b, 1'b0};
                            m3_q    <= {2'b00, div_if.i_b} + {1'b0, div_if.i_b, 1'b0};
                            cnt_q   <= CW'(N - 1);
                            dbz_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end else begin
                            quot_q  <= '1;
                            rem_q   <= div_if.i_a;
                            dbz_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                CALC: begin
                    pr_q  <= pr_d[ibits-1:0];
                    q_q   <= q_d;
                    da_q  <= da_q << 2;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quot_q  <= q_d;
                        rem_q   <= pr_d[ibits-1:0];
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_if.o_busy  = busy_q;
    assign div_if.o_valid = valid_q;
    assign div_if.o_quot  = quot_q;
    assign div_if.o_rem   = rem_q;
    assign div_if.o_dbz   = dbz_q;
endmodule

// File: tb/tb_idiv_radix4_iter.sv
// tb/tb_idiv_radix4_iter.sv - directed self-checking bench for idiv_radix4_iter
module tb_idiv_radix4_iter;
    localparam int IB = 22;
    localparam logic [IB-1:0] ALL1 = '1;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    idiv_radix4_iter_if #(.ibits(IB)) div_if ();

    idiv_radix4_iter #(.ibits(IB)) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .div_if (div_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic [IB-1:0] a, input logic [IB-1:0] b,
                           input logic [IB-1:0] q, input logic [IB-1:0] r, input logic dz);
        int k;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        div_if.i_a   = a;
        div_if.i_b   = b;
        div_if.i_ena = 1'b1;
        k = 0;
        busy_cnt = 0;
        seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            div_if.i_ena = 1'b0;
            div_if.i_a   = IB'($urandom);
            div_if.i_b   = IB'($urandom);
            if (div_if.o_busy) busy_cnt++;
            if (div_if.o_valid) seen = 1;
        end
        check_eq({tag, " latency"}, 64'(k), dz ? 64'd1 : 64'd12);
        check_eq({tag, " busy_cycles"}, 64'(busy_cnt), dz ? 64'd0 : 64'd11);
        check_eq({tag, " quot"}, 64'(div_if.o_quot), 64'(q));
        check_eq({tag, " rem"}, 64'(div_if.o_rem), 64'(r));
        check_eq({tag, " dbz"}, 64'(div_if.o_dbz), 64'(dz));
        @(negedge clk);
        check_eq({tag, " valid_pulse_end"}, 64'(div_if.o_valid), 64'd0);
    endtask

    logic [IB-1:0] va [3];
    logic [IB-1:0] vb [3];
    logic [IB-1:0] vq [3];
    logic [IB-1:0] vr [3];

    initial begin
        int bad;
        bit seen;
        logic [IB-1:0] ra, rb, rq, rr;

        div_if.i_ena = 1'b0;
        div_if.i_a   = '0;
        div_if.i_b   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst busy",  64'(div_if.o_busy),  64'd0);
        check_eq("rst valid", 64'(div_if.o_valid), 64'd0);
        check_eq("rst quot",  64'(div_if.o_quot),  64'd0);
        check_eq("rst rem",   64'(div_if.o_rem),   64'd0);
        check_eq("rst dbz",   64'(div_if.o_dbz),   64'd0);
        nrst = 1'b1;

        run_div("d100_7",   22'd100,     22'd7,        22'd14,       22'd2,     1'b0);
        run_div("max_1",    22'h3FFFFF,  22'd1,        22'h3FFFFF,   22'd0,     1'b0);
        run_div("max_max",  22'h3FFFFF,  22'h3FFFFF,   22'd1,        22'd0,     1'b0);
        run_div("d5_9",     22'd5,       22'd9,        22'd0,        22'd5,     1'b0);
        run_div("dbz",      22'd1234,    22'd0,        ALL1,         22'd1234,  1'b1);
        run_div("d1e6_1e3", 22'd1000000, 22'd1000,     22'd1000,     22'd0,     1'b0);
        run_div("max_2",    22'h3FFFFF,  22'd2,        22'h1FFFFF,   22'd1,     1'b0);
        run_div("max_p16",  22'h3FFFFF,  22'd65536,    22'd63,       22'd65535, 1'b0);
        run_div("d123456",  22'd123456,  22'd789,      22'd156,      22'd372,   1'b0);
        run_div("after_dbz",22'd100,     22'd7,        22'd14,       22'd2,     1'b0);

        // Back-to-back: i_ena held high, fresh start on every DONE cycle.
        va[0] = 22'd1000; vb[0] = 22'd3;   vq[0] = 22'd333; vr[0] = 22'd1;
        va[1] = 22'd50;   vb[1] = 22'd50;  vq[1] = 22'd1;   vr[1] = 22'd0;
        va[2] = 22'd777;  vb[2] = 22'd256; vq[2] = 22'd3;   vr[2] = 22'd9;
        @(negedge clk);
        div_if.i_a = va[0];
        div_if.i_b = vb[0];
        div_if.i_ena = 1'b1;
        bad = 0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k % 12 == 0) begin
                check_eq("b2b valid", 64'(div_if.o_valid), 64'd1);
                check_eq("b2b quot", 64'(div_if.o_quot), 64'(vq[k/12-1]));
                check_eq("b2b rem",  64'(div_if.o_rem),  64'(vr[k/12-1]));
                if (k / 12 < 3) begin
                    div_if.i_a = va[k/12];
                    div_if.i_b = vb[k/12];
                end else begin
                    div_if.i_ena = 1'b0;
                end
            end else begin
                if (div_if.o_valid) bad++;
                div_if.i_a = IB'($urandom);
                div_if.i_b = IB'($urandom);
            end
        end
        check_eq("b2b stray_valid", 64'(bad), 64'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        div_if.i_a = 22'd123456;
        div_if.i_b = 22'd789;
        div_if.i_ena = 1'b1;
        @(negedge clk);
        div_if.i_ena = 1'b0;
        repeat (4) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check_eq("midrst busy",  64'(div_if.o_busy),  64'd0);
        check_eq("midrst valid", 64'(div_if.o_valid), 64'd0);
        check_eq("midrst quot",  64'(div_if.o_quot),  64'd0);
        check_eq("midrst rem",   64'(div_if.o_rem),   64'd0);
        check_eq("midrst dbz",   64'(div_if.o_dbz),   64'd0);
        @(negedge clk);
        nrst = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (div_if.o_valid) seen = 1;
        end
        check_eq("midrst no_valid", 64'(seen), 64'd0);
        run_div("post_rst", 22'd999, 22'd10, 22'd99, 22'd9, 1'b0);

        // Random operands, including zero and power-of-two divisors.
        for (int i = 0; i < 150; i++) begin
            ra = IB'($urandom);
            if (i % 10 == 0)      rb = '0;
            else if (i % 7 == 0)  rb = IB'(1) << (i % IB);
            else if (i % 3 == 0)  rb = IB'($urandom_range(1, 300));
            else                  rb = IB'($urandom);
            if (rb == '0) begin
                rq = ALL1;
                rr = ra;
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            run_div("rand", ra, rb, rq, rr, rb == '0);
            if (rb != '0) begin
                check_eq("rand invariant",
                         64'(div_if.o_quot) * 64'(rb) + 64'(div_if.o_rem), 64'(ra));
                check_eq("rand rem_lt_b", 64'(div_if.o_rem < rb), 64'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
